// File: rtl/led_frame_sequencer_pkg.sv
// Shared definitions for the LED frame sequencer: FSM encoding, frame geometry
// and driver-RAM address width.
package led_frame_sequencer_pkg;

    localparam int DEF_WORDS  = 132;
    localparam int DRV_ADDR_W = 8;
    localparam int DATA_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

endpackage

// File: rtl/led_frame_sequencer_bank.sv
// One frame bank: single write port, synchronous read-first read port.
// Contents are never reset, so a frame survives a sequencer reset.
module led_frame_bank
    import led_frame_sequencer_pkg::*;
#(
    parameter int WORDS = DEF_WORDS
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DRV_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DRV_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rd_data_q;

    // Read and write share an edge; the non-blocking write makes the read return old data.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(WORDS))) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (32'(rd_addr) < 32'(WORDS)) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Double-buffered LED frame sequencer: periodic tick, bank copy into the
// matrix driver RAM, start pulse and ready handshake with the driver.
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int WORDS    = DEF_WORDS,
    parameter int PERIOD_W = 16
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [DATA_W-1:0]     in_cpu_data,
    input  logic [8:0]            in_cpu_addr,
    input  logic                  in_cpu_we,
    input  logic                  in_swap,
    input  logic                  in_enable,
    input  logic [PERIOD_W-1:0]   in_period,
    input  logic                  in_drv_ready,
    output logic [DATA_W-1:0]     out_drv_data,
    output logic [DRV_ADDR_W-1:0] out_drv_addr,
    output logic                  out_drv_we,
    output logic                  out_drv_start,
    output logic                  out_front_bank,
    output logic                  out_swap_ack,
    output logic                  out_busy,
    output logic                  out_overrun
);

    localparam int IDX_W = DRV_ADDR_W + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS);
    localparam logic [IDX_W-1:0]      IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DRV_ADDR_W-1:0] ADDR_ONE = {{(DRV_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W:0]     CNT_ONE  = {{PERIOD_W{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic                  pending_q, pending_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  front_q, front_d;
    logic                  swap_ack_q, swap_ack_d;
    logic                  overrun_q, overrun_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [PERIOD_W:0]     cnt_inc;
    logic [PERIOD_W:0]     period_eff;
    logic                  tick;
    logic                  start_frame;
    logic                  cpu_in_range;
    logic [1:0]            bank_we;
    logic [DATA_W-1:0]     bank_rd [2];
    logic [DRV_ADDR_W-1:0] idx_lo;

    assign cpu_in_range = 32'(in_cpu_addr[7:0]) < 32'(WORDS);
    assign bank_we[0]   = in_cpu_we && cpu_in_range && !in_cpu_addr[8];
    assign bank_we[1]   = in_cpu_we && cpu_in_range &&  in_cpu_addr[8];
    assign idx_lo       = idx_q[DRV_ADDR_W-1:0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        led_frame_bank #(.WORDS(WORDS)) u_bank (
            .clk     (in_clk),
            .wr_en   (bank_we[b]),
            .wr_addr (in_cpu_addr[7:0]),
            .wr_data (in_cpu_data),
            .rd_addr (idx_lo),
            .rd_data (bank_rd[b])
        );
    end

    // Period counter; a period of 0 behaves as 1. The tick is registered.
    always_comb begin
        period_eff = (in_period == '0) ? CNT_ONE : {1'b0, in_period};
        cnt_inc    = {1'b0, cnt_q} + CNT_ONE;
        cnt_d      = '0;
        tick_d     = 1'b0;
        if (in_enable) begin
            if (cnt_inc >= period_eff) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_inc[PERIOD_W-1:0];
            end
        end
    end

    assign tick = tick_q && in_enable;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        swap_pending_d = swap_pending_q || in_swap;
        front_d        = front_q;
        swap_ack_d     = 1'b0;
        overrun_d      = overrun_q;
        idx_d          = idx_q;
        start_frame    = (state_q == ST_IDLE) && in_enable && in_drv_ready &&
                         (tick || pending_q);

        // A tick that cannot start a frame now is remembered once; a second one is an overrun.
        if (tick && !start_frame) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end
        if (start_frame || !in_enable) begin
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_d = ST_COPY;
                    idx_d   = '0;
                    if (swap_pending_q) begin
                        front_d        = !front_q;
                        swap_ack_d     = 1'b1;
                        swap_pending_d = in_swap;
                    end
                end
            end
            ST_COPY: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_START;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_START:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!in_drv_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (in_drv_ready)  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tick_q         <= 1'b0;
            pending_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            front_q        <= 1'b0;
            swap_ack_q     <= 1'b0;
            overrun_q      <= 1'b0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tick_q         <= tick_d;
            pending_q      <= pending_d;
            swap_pending_q <= swap_pending_d;
            front_q        <= front_d;
            swap_ack_q     <= swap_ack_d;
            overrun_q      <= overrun_d;
            idx_q          <= idx_d;
        end
    end

    // Word k is read in copy cycle k and written to the driver one cycle later.
    assign out_drv_we     = (state_q == ST_COPY) && (idx_q != '0);
    assign out_drv_addr   = out_drv_we ? (idx_lo - ADDR_ONE) : '0;
    assign out_drv_data   = out_drv_we ? bank_rd[front_q] : '0;
    assign out_drv_start  = (state_q == ST_START);
    assign out_busy       = (state_q != ST_IDLE);
    assign out_front_bank = front_q;
    assign out_swap_ack   = swap_ack_q;
    assign out_overrun    = overrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a model of the driver RAM.
module tb_led_frame_sequencer;

    localparam int WORDS = 132;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [15:0] in_cpu_data;
    logic [8:0]  in_cpu_addr;
    logic        in_cpu_we;
    logic        in_swap;
    logic        in_enable;
    logic [15:0] in_period;
    logic        in_drv_ready;
    logic [15:0] out_drv_data;
    logic [7:0]  out_drv_addr;
    logic        out_drv_we;
    logic        out_drv_start;
    logic        out_front_bank;
    logic        out_swap_ack;
    logic        out_busy;
    logic        out_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int ack_cnt   = 0;
    logic [15:0] drv_ram [256];

    always #5 in_clk = ~in_clk;

    led_frame_sequencer #(.WORDS(WORDS), .PERIOD_W(16)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_cpu_data    (in_cpu_data),
        .in_cpu_addr    (in_cpu_addr),
        .in_cpu_we      (in_cpu_we),
        .in_swap        (in_swap),
        .in_enable      (in_enable),
        .in_period      (in_period),
        .in_drv_ready   (in_drv_ready),
        .out_drv_data   (out_drv_data),
        .out_drv_addr   (out_drv_addr),
        .out_drv_we     (out_drv_we),
        .out_drv_start  (out_drv_start),
        .out_front_bank (out_front_bank),
        .out_swap_ack   (out_swap_ack),
        .out_busy       (out_busy),
        .out_overrun    (out_overrun)
    );

    always @(posedge in_clk) begin
        if (out_drv_we) drv_ram[out_drv_addr] <= out_drv_data;
    end

    always @(negedge in_clk) begin
        if (out_drv_start) start_cnt++;
        if (out_swap_ack)  ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [15:0] d);
        in_cpu_addr = a;
        in_cpu_data = d;
        in_cpu_we   = 1'b1;
        @(negedge in_clk);
        in_cpu_we   = 1'b0;
    endtask

    // Returns at the negedge of copy cycle 0.
    task automatic wait_busy(input string tag);
        int n = 0;
        while (!out_busy && n < 3000) begin
            @(negedge in_clk);
            n++;
        end
        check(tag, 32'(out_busy), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!out_drv_start && n < 3000) begin
            @(negedge in_clk);
            n++;
        end
        check(tag, 32'(out_drv_start), 32'd1);
    endtask

    task automatic handshake();
        int n = 0;
        @(negedge in_clk);
        check("start_width", 32'(out_drv_start), 32'd0);
        in_drv_ready = 1'b0;
        repeat (2) @(negedge in_clk);
        in_drv_ready = 1'b1;
        while (out_busy && n < 20) begin
            @(negedge in_clk);
            n++;
        end
        check("frame_done", 32'(out_busy), 32'd0);
    endtask

    initial begin
        int lat;
        int errs;
        int sc;
        in_rst       = 1'b0;
        in_cpu_data  = '0;
        in_cpu_addr  = '0;
        in_cpu_we    = 1'b0;
        in_swap      = 1'b0;
        in_enable    = 1'b0;
        in_period    = 16'd0;
        in_drv_ready = 1'b1;
        for (int i = 0; i < 256; i++) drv_ram[i] = 16'h0000;

        repeat (2) @(negedge in_clk);
        check("rst_busy",    32'(out_busy),       32'd0);
        check("rst_we",      32'(out_drv_we),     32'd0);
        check("rst_start",   32'(out_drv_start),  32'd0);
        check("rst_front",   32'(out_front_bank), 32'd0);
        check("rst_ack",     32'(out_swap_ack),   32'd0);
        check("rst_overrun", 32'(out_overrun),    32'd0);
        check("rst_addr",    32'(out_drv_addr),   32'd0);
        check("rst_data",    32'(out_drv_data),   32'd0);
        in_rst = 1'b1;
        @(negedge in_clk);

        for (int k = 0; k < WORDS; k++) cpu_write({1'b0, 8'(k)}, 16'(k + 1));
        for (int k = 0; k < WORDS; k++) cpu_write({1'b1, 8'(k)}, 16'hA000 + 16'(k));
        cpu_write(9'h084, 16'hDEAD);
        cpu_write(9'h184, 16'hBEEF);
        check("idle_no_enable", 32'(out_busy), 32'd0);

        // First frame: latency from enable to the start pulse.
        in_period = 16'd1000;
        in_enable = 1'b1;
        lat = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge in_clk);
            if (out_drv_start) begin
                lat = i;
                break;
            end
        end
        check("first_start_latency", 32'(lat), 32'd1134);
        handshake();
        errs = 0;
        for (int k = 0; k < WORDS; k++) if (drv_ram[k] !== 16'(k + 1)) errs++;
        check("ram_bank0", 32'(errs), 32'd0);
        check("ram_word132", 32'(drv_ram[132]), 32'd0);
        check("start_count", 32'(start_cnt), 32'd1);
        check("front_f1", 32'(out_front_bank), 32'd0);

        // Swap requested mid-frame takes effect on the next frame.
        in_enable = 1'b0;
        @(negedge in_clk);
        in_period = 16'd200;
        in_enable = 1'b1;
        wait_busy("busy_a");
        repeat (10) @(negedge in_clk);
        in_swap = 1'b1;
        @(negedge in_clk);
        in_swap = 1'b0;
        check("front_mid_a", 32'(out_front_bank), 32'd0);
        check("ack_none_a", 32'(ack_cnt), 32'd0);
        wait_start("start_a");
        handshake();

        wait_busy("busy_b");
        check("ack_pulse_b", 32'(out_swap_ack), 32'd1);
        check("front_b", 32'(out_front_bank), 32'd1);
        repeat (5) @(negedge in_clk);
        cpu_write(9'h105, 16'h5555);
        wait_start("start_b");
        handshake();
        errs = 0;
        for (int k = 0; k < WORDS; k++) if (drv_ram[k] !== 16'hA000 + 16'(k)) errs++;
        check("ram_bank1_readfirst", 32'(errs), 32'd0);
        check("ack_count", 32'(ack_cnt), 32'd1);

        wait_busy("busy_c");
        wait_start("start_c");
        handshake();
        check("ram_word5_new", 32'(drv_ram[5]), 32'h5555);
        check("ack_count_c", 32'(ack_cnt), 32'd1);

        // Ready held low across several ticks.
        in_enable = 1'b0;
        @(negedge in_clk);
        in_period    = 16'd10;
        in_drv_ready = 1'b0;
        in_enable    = 1'b1;
        repeat (50) @(negedge in_clk);
        check("overrun_set", 32'(out_overrun), 32'd1);
        check("held_idle", 32'(out_busy), 32'd0);
        in_period = 16'hFFFF;
        @(negedge in_clk);
        sc = start_cnt;
        in_drv_ready = 1'b1;
        wait_start("start_pending");
        handshake();
        repeat (300) @(negedge in_clk);
        check("one_pending_frame", 32'(start_cnt - sc), 32'd1);
        check("overrun_sticky", 32'(out_overrun), 32'd1);

        // Reset in the middle of a copy.
        in_enable = 1'b0;
        @(negedge in_clk);
        in_period = 16'd200;
        in_enable = 1'b1;
        wait_busy("busy_r");
        repeat (40) @(negedge in_clk);
        check("we_before_rst", 32'(out_drv_we), 32'd1);
        in_rst = 1'b0;
        #1;
        check("rst_mid_we", 32'(out_drv_we), 32'd0);
        check("rst_mid_busy", 32'(out_busy), 32'd0);
        check("rst_mid_front", 32'(out_front_bank), 32'd0);
        check("rst_mid_overrun", 32'(out_overrun), 32'd0);
        @(negedge in_clk);
        in_rst = 1'b1;
        wait_busy("busy_d");
        wait_start("start_d");
        handshake();
        errs = 0;
        for (int k = 0; k < WORDS; k++) if (drv_ram[k] !== 16'(k + 1)) errs++;
        check("ram_bank0_retained", 32'(errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
